// File: rtl/debounce_bank_if.sv
// Button-side bundle: raw inputs toward the conditioner, clean levels and
// one-cycle event strobes back toward the control logic.
interface debounce_bank_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_long
  );
endinterface

// File: rtl/debounce_bank.sv
// N independent push-button channels: polarity fix, 2-FF synchroniser,
// symmetric debounce and a RELEASED/PRESSED/HELD event FSM per channel.
module debounce_bank #(
  parameter int N_BTN      = 4,
  parameter int MIN_TIME   = 5000,
  parameter int LONG_TIME  = 1000000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            reset,
  debounce_bank_if.slave  bus
);
  localparam int DB_W   = $clog2(MIN_TIME + 1);
  localparam int HOLD_W = $clog2(LONG_TIME + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MIN_TIME - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TIME - 1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [N_BTN-1:0] raw_fixed;
  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;
  logic [N_BTN-1:0] long_vec;

  assign raw_fixed = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      logic [1:0]        sync_reg;
      logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
      logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
      state_t            state_reg, state_next;
      logic              press_reg, press_next;
      logic              release_reg, release_next;
      logic              long_reg, long_next;
      logic              stable;
      logic              level;
      logic              toggle;

      assign stable = sync_reg[1];
      assign level  = (state_reg != RELEASED);
      // The debounced level lives in the FSM state; toggle is the qualified edge.
      assign toggle = (stable != level) && (db_cnt_reg == DB_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg     <= 2'b00;
          db_cnt_reg   <= '0;
          hold_cnt_reg <= '0;
          state_reg    <= RELEASED;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          long_reg     <= 1'b0;
        end else begin
          sync_reg     <= {sync_reg[0], raw_fixed[gi]};
          db_cnt_reg   <= db_cnt_next;
          hold_cnt_reg <= hold_cnt_next;
          state_reg    <= state_next;
          press_reg    <= press_next;
          release_reg  <= release_next;
          long_reg     <= long_next;
        end
      end

      always_comb begin
        db_cnt_next   = '0;
        hold_cnt_next = hold_cnt_reg;
        state_next    = state_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;

        if ((stable != level) && !toggle) begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end

        case (state_reg)
          RELEASED: begin
            if (toggle) begin
              state_next    = PRESSED;
              press_next    = 1'b1;
              hold_cnt_next = '0;
            end
          end
          PRESSED: begin
            // A debounced fall wins over a coincident hold expiry.
            if (toggle) begin
              state_next    = RELEASED;
              release_next  = 1'b1;
              hold_cnt_next = '0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
              state_next = HELD;
              long_next  = 1'b1;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
          HELD: begin
            if (toggle) begin
              state_next    = RELEASED;
              release_next  = 1'b1;
              hold_cnt_next = '0;
            end
          end
          default: begin
            state_next    = RELEASED;
            hold_cnt_next = '0;
          end
        endcase
      end

      assign level_vec[gi]   = level;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;
      assign long_vec[gi]    = long_reg;
    end
  endgenerate

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.btn_long    = long_vec;
endmodule

// File: tb/tb_debounce_bank.sv
// Two instances (active-high and active-low, driven with complementary raw
// inputs) checked every cycle against an edge-indexed reference model.
module tb_debounce_bank;
  localparam int N  = 2;
  localparam int MT = 4;
  localparam int LT = 10;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debounce_bank_if #(.N_BTN(N)) bus_a ();
  debounce_bank_if #(.N_BTN(N)) bus_b ();

  debounce_bank #(.N_BTN(N), .MIN_TIME(MT), .LONG_TIME(LT), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  debounce_bank #(.N_BTN(N), .MIN_TIME(MT), .LONG_TIME(LT), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  exp_t exp_q[$];

  // Reference model: edge k samples x[k]; the synchronised value used at edge
  // k is x[k-2]. The level flips at edge k when every one of the last MT edges
  // (all strictly after the previous flip) saw a value different from it.
  int k;
  logic [N-1:0] xh[$];
  logic [N-1:0] m_level;
  int last_tog[N];
  int press_edge[N];
  bit long_done[N];

  function automatic logic [N-1:0] s_at(input int e);
    if (e - 2 >= 1) return xh[e - 3];
    return '0;
  endfunction

  task automatic model_reset();
    k = 0;
    xh.delete();
    m_level = '0;
    for (int c = 0; c < N; c++) begin
      last_tog[c] = 0;
      press_edge[c] = 0;
      long_done[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] v, output exp_t e);
    logic [N-1:0] sv;
    bit all_diff;
    e = '0;
    k++;
    xh.push_back(v);
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < MT; j++) begin
        sv = s_at(k - j);
        if (k - j <= last_tog[c]) all_diff = 1'b0;
        else if (sv[c] == m_level[c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        last_tog[c] = k;
        if (!m_level[c]) begin
          m_level[c] = 1'b1;
          e.press[c] = 1'b1;
          press_edge[c] = k;
          long_done[c] = 1'b0;
        end else begin
          m_level[c] = 1'b0;
          e.rel[c] = 1'b1;
        end
      end else if (m_level[c] && !long_done[c] && (k - press_edge[c] == LT)) begin
        e.lng[c] = 1'b1;
        long_done[c] = 1'b1;
      end
    end
    e.level = m_level;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, predict.
  task automatic cycle(input logic [N-1:0] v);
    exp_t e;
    bus_a.btn_in = v;
    bus_b.btn_in = ~v;
    model_edge(v, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input logic [N-1:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  task automatic check_zero(input string name, input exp_t act);
    compared++;
    if (act !== '0) begin
      mismatched++;
      $display("FAIL %s: got %b required 0", name, act);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    bus_a.btn_in = v;
    bus_b.btn_in = ~v;
    #2 reset = 1'b1;
    #1;
    check_zero("reset_a", {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_long});
    check_zero("reset_b", {bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_long});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: pop one prediction per rising edge and compare both instances.
  always @(posedge clk) begin
    exp_t e, a, b;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_long};
      b = {bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_long};
      compared += 2;
      if (a !== e) begin
        mismatched++;
        $display("FAIL dut_a cyc %0d: got lvl=%b prs=%b rel=%b lng=%b required lvl=%b prs=%b rel=%b lng=%b",
                 cyc, a.level, a.press, a.rel, a.lng, e.level, e.press, e.rel, e.lng);
      end
      if (b !== e) begin
        mismatched++;
        $display("FAIL dut_b cyc %0d: got lvl=%b prs=%b rel=%b lng=%b required lvl=%b prs=%b rel=%b lng=%b",
                 cyc, b.level, b.press, b.rel, b.lng, e.level, e.press, e.rel, e.lng);
      end
      if ((e.press | e.rel | e.lng) != '0)
        $display("cyc %0d event: lvl=%b prs=%b rel=%b lng=%b", cyc, e.level, e.press, e.rel, e.lng);
    end
  end

  initial begin
    model_reset();
    bus_a.btn_in = 2'b11;
    bus_b.btn_in = 2'b00;
    @(negedge clk);
    do_reset(2'b11);

    // Both channels pressed out of reset, then reset mid-press and re-qualify.
    run(2'b11, 12);
    do_reset(2'b11);
    run(2'b11, 10);
    run(2'b00, 12);

    // Clean press/release on ch0.
    run(2'b01, 14);
    run(2'b00, 10);

    // Bounce rejection on ch0, then a real press.
    for (int r = 0; r < 5; r++) begin
      run(2'b01, 3);
      run(2'b00, 1);
    end
    run(2'b00, 6);
    run(2'b01, 10);
    run(2'b00, 10);

    // Long press on ch1.
    run(2'b10, 25);
    run(2'b00, 10);

    // Short press, then immediate re-press reaching long.
    run(2'b10, 14);
    run(2'b00, 6);
    run(2'b10, 20);
    run(2'b00, 10);

    // Simultaneous press ch0 / release ch1 (complementary on the low-active DUT).
    run(2'b10, 10);
    run(2'b01, 10);
    run(2'b00, 10);

    // Randomised segments with occasional resets.
    for (int s = 0; s < 60; s++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) do_reset(v);
      run(v, $urandom_range(1, 16));
    end
    run(2'b00, 12);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
